// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill command engine for the VGA framebuffer write port.
// Accepts one fill command per valid/ready handshake, clips it to the visible area and
// emits one framebuffer write per cycle in raster order. The address is updated
// incrementally and no multiplier is used per pixel.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready     command handshake; ready is high only while idle
//   cmd_x/y/w/h         rectangle origin and size in pixels
//   cmd_color           fill colour
//   write_enable        framebuffer write strobe
//   write_addr          row*H_VISIBLE_AREA + col of the current write
//   pixel_in            colour of the current write (held when write_enable is low)
//   busy                high while a command is being processed
//   done                one-cycle pulse when a command completes
module vga_rect_fill #(
  parameter int unsigned H_VISIBLE_AREA = 50,
  parameter int unsigned V_VISIBLE_AREA = 50,
  parameter int unsigned PIXEL_WIDTH    = 12,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned COORD_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_WIDTH-1:0] cmd_x,
  input  logic [COORD_WIDTH-1:0] cmd_y,
  input  logic [COORD_WIDTH-1:0] cmd_w,
  input  logic [COORD_WIDTH-1:0] cmd_h,
  input  logic [PIXEL_WIDTH-1:0] cmd_color,
  output logic                   write_enable,
  output logic [ADDR_WIDTH-1:0]  write_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CW1 = COORD_WIDTH + 1;
  localparam logic [COORD_WIDTH:0]   HLim     = CW1'(H_VISIBLE_AREA);
  localparam logic [COORD_WIDTH:0]   VLim     = CW1'(V_VISIBLE_AREA);
  localparam logic [COORD_WIDTH:0]   ExtOne   = CW1'(1);
  localparam logic [COORD_WIDTH-1:0] CoordOne = COORD_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  HStep    = ADDR_WIDTH'(H_VISIBLE_AREA);
  localparam logic [ADDR_WIDTH-1:0]  AddrOne  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                 state_q;
  logic [COORD_WIDTH-1:0] x_start_q, x_last_q, y_last_q, col_q, row_q;
  logic [ADDR_WIDTH-1:0]  row_base_q, addr_q;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic                   we_q, done_q, ready_q, busy_q;

  logic [COORD_WIDTH:0]   x_sum, y_sum, x_end, y_end;
  logic [ADDR_WIDTH-1:0]  y_base, next_base;
  logic                   cmd_empty, accept, col_wrap, fill_last;

  always_comb begin
    // Extra bit keeps x+w / y+h from wrapping before the clip.
    x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
    x_end     = (x_sum > HLim) ? HLim : x_sum;
    y_end     = (y_sum > VLim) ? VLim : y_sum;
    cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                ({1'b0, cmd_x} >= HLim) || ({1'b0, cmd_y} >= VLim);
    // Constant-coefficient product, evaluated once per accepted command.
    y_base    = ADDR_WIDTH'(cmd_y) * HStep;
    next_base = row_base_q + HStep;
    accept    = cmd_valid && ready_q;
    col_wrap  = (col_q == x_last_q);
    fill_last = col_wrap && (row_q == y_last_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_start_q  <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      pix_q      <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (cmd_empty) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // First write goes out on the accepting edge itself.
              state_q    <= StFill;
              we_q       <= 1'b1;
              addr_q     <= y_base + ADDR_WIDTH'(cmd_x);
              pix_q      <= cmd_color;
              row_base_q <= y_base;
              x_start_q  <= cmd_x;
              col_q      <= cmd_x;
              row_q      <= cmd_y;
              x_last_q   <= COORD_WIDTH'(x_end - ExtOne);
              y_last_q   <= COORD_WIDTH'(y_end - ExtOne);
            end
          end
        end
        StFill: begin
          if (fill_last) begin
            state_q <= StDone;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else if (col_wrap) begin
            col_q      <= x_start_q;
            row_q      <= row_q + CoordOne;
            row_base_q <= next_base;
            addr_q     <= next_base + ADDR_WIDTH'(x_start_q);
          end else begin
            col_q  <= col_q + CoordOne;
            addr_q <= addr_q + AddrOne;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready    = ready_q;
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign pixel_in     = pix_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: the driver pushes the expected writes and done pulse
// of each accepted command (from a plain raster model of the clipped rectangle); a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_vga_rect_fill;

  localparam int H = 50;
  localparam int V = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [11:0] pixel_in;
  logic        busy;
  logic        done;

  vga_rect_fill dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .pixel_in     (pixel_in),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [11:0] pix;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_wr[$];
  int unsigned exp_done[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int unsigned last_addr = 0;
  logic [11:0] last_pix = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: every pixel of the clipped rectangle in raster order, one per cycle from e.
  task automatic model(input int x, input int y, input int w, input int h,
                       input logic [11:0] c, input int unsigned e, output int k);
    int  xe, ye;
    bit  empty;
    wr_t t;
    xe    = (x + w < H) ? x + w : H;
    ye    = (y + h < V) ? y + h : V;
    empty = (w == 0) || (h == 0) || (x >= H) || (y >= V);
    k     = 0;
    if (!empty) begin
      for (int r = y; r < ye; r++) begin
        for (int col = x; col < xe; col++) begin
          t.addr = r * H + col;
          t.pix  = c;
          t.cyc  = e + k;
          exp_wr.push_back(t);
          k++;
        end
      end
    end
    exp_done.push_back(e + k);
  endtask

  // Presents a command (cmd_valid left high) and returns the accepting edge index.
  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [11:0] c, output int unsigned e, output int k);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x = 16'(x); cmd_y = 16'(y); cmd_w = 16'(w); cmd_h = 16'(h); cmd_color = c;
    n = 0;
    while (!cmd_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      e = 0;
      k = 0;
      return;
    end
    e = cyc + 1;
    @(posedge clk);
    #1;
    model(x, y, w, h, c, e, k);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0 || !cmd_ready) && n < 6000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 6000) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", busy, write_enable || done);
      chk("ready", cmd_ready, !busy);
      if (write_enable) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t t;
          t = exp_wr.pop_front();
          chk("addr", write_addr, t.addr);
          chk("pixel", pixel_in, t.pix);
          chk("write_cycle", cyc, t.cyc);
          last_addr = t.addr;
          last_pix  = t.pix;
        end
      end else begin
        chk("addr_hold", write_addr, last_addr);
        chk("pixel_hold", pixel_in, last_pix);
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ea, eb;
    int k, n;
    int x, y, w, h;

    #23;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_pix", pixel_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    #1 reset = 1'b0;

    // Basic 3x2 fill.
    send(2, 3, 3, 2, 12'hF00, ea, k);
    cmd_valid = 1'b0;
    chk("t1_count", k, 6);
    wait_idle();

    // Clipped at the bottom-right corner.
    send(48, 49, 5, 5, 12'h0F0, ea, k);
    cmd_valid = 1'b0;
    chk("t2_count", k, 2);
    wait_idle();

    // Two empty commands held back to back.
    send(5, 5, 0, 4, 12'h123, ea, k);
    send(50, 0, 3, 3, 12'h456, eb, k);
    cmd_valid = 1'b0;
    chk("t3_empty_gap", eb - ea, 2);
    wait_idle();

    // Two 1x1 commands held back to back.
    send(0, 0, 1, 1, 12'hABC, ea, k);
    send(49, 49, 1, 1, 12'h0DE, eb, k);
    cmd_valid = 1'b0;
    chk("t4_b2b_gap", eb - ea, 3);
    wait_idle();

    // Reset in the middle of a full-screen fill.
    send(0, 0, 50, 50, 12'h777, ea, k);
    cmd_valid = 1'b0;
    n = 0;
    while (exp_wr.size() > 2500 - 10 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t5_reached_write10", 2500 - exp_wr.size(), 10);
    reset = 1'b1;
    #1;
    chk("t5_we_async", write_enable, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_done_async", done, 0);
    exp_wr.delete();
    exp_done.delete();
    last_addr = 0;
    last_pix  = '0;
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_ready_after", cmd_ready, 1);
    send(10, 10, 3, 2, 12'h00F, ea, k);
    cmd_valid = 1'b0;
    wait_idle();

    // Randomised commands, some held back to back.
    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(0, 55);
      y = $urandom_range(0, 55);
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 10);
      h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 10);
      send(x, y, w, h, 12'($urandom), ea, k);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Full screen.
    send(0, 0, 50, 50, 12'h5A5, ea, k);
    cmd_valid = 1'b0;
    chk("t6_count", k, 2500);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
